// File: rtl/uart_rx_controller.sv
// Receive-side UART controller: receiver handshake, error-tagged RX FIFO, config register, irq.
// Optional idle-timeout interrupt and `timeout` port enabled by defining UART_RX_TIMEOUT_EN.

package uart_pkg;
   typedef enum logic [2:0] {
      BAUD_9600, BAUD_19200, BAUD_38400, BAUD_57600, BAUD_115200
   } baud_e;
   typedef enum logic [1:0] {DATA_BITS_5, DATA_BITS_6, DATA_BITS_7, DATA_BITS_8} data_bits_e;
   typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_e;
   typedef enum logic [0:0] {STOP_BITS_1, STOP_BITS_2} stop_bits_e;

   typedef struct packed {
      baud_e      baud;
      data_bits_e data_bits;
      parity_e    parity;
      stop_bits_e stop_bits;
      logic       lsb_first;
   } uart_config_t;
endpackage

module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH          = 8,
   parameter int unsigned IRQ_THRESHOLD  = 1,
   parameter int unsigned TIMEOUT_CYCLES = 40000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_ready,
   input  logic [7:0]               rx_data,
   input  logic                     frame_error,
   input  logic                     parity_error,
   output logic                     clear_rx_ready,
   output uart_config_t             uart_config,
   input  logic                     cfg_wr_en,
   input  uart_config_t             cfg_wr_data,
   input  logic                     rd_en,
   output logic [9:0]               rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overrun,
   input  logic                     status_clr,
`ifdef UART_RX_TIMEOUT_EN
   output logic                     timeout,
`endif
   output logic                     irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [0:0] StWait = 1'b0;
   localparam logic [0:0] StAck  = 1'b1;

   localparam uart_config_t CfgDefault = '{
      baud: BAUD_115200, data_bits: DATA_BITS_8, parity: PARITY_NONE,
      stop_bits: STOP_BITS_1, lsb_first: 1'b1
   };

   logic [0:0]    state_q, state_d;
   logic [9:0]    mem_q [DEPTH];
   logic [9:0]    mem_d [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [9:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          overrun_q, overrun_d;
   uart_config_t  cfg_q, cfg_d;
   logic          capture, push, drop, pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // A config write swallows a pending frame: it is acknowledged but never captured.
   assign capture = (state_q == StWait) && rx_ready && !cfg_wr_en;
   assign push    = capture && !full;
   assign drop    = capture && full;
   assign pop     = rd_en && !empty;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StWait:  if (rx_ready) state_d = StAck;
         StAck:   if (!rx_ready) state_d = StWait;
         default: state_d = StWait;
      endcase

      mem_d = mem_q;
      if (push) mem_d[tail_q] = {parity_error, frame_error, rx_data};

      head_d  = pop  ? head_q + AW'(1) : head_q;
      tail_d  = push ? tail_q + AW'(1) : tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (cfg_wr_en) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end

      rd_data_d  = pop ? mem_q[head_q] : rd_data_q;
      rd_valid_d = pop;

      overrun_d = overrun_q;
      if (status_clr) overrun_d = 1'b0;
      if (drop)       overrun_d = 1'b1;

      cfg_d = cfg_wr_en ? cfg_wr_data : cfg_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StWait;
         mem_q      <= '{default: '0};
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         cfg_q      <= CfgDefault;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
         cfg_q      <= cfg_d;
      end
   end

   assign clear_rx_ready = (state_q == StAck);
   assign uart_config    = cfg_q;
   assign rd_data        = rd_data_q;
   assign rd_valid       = rd_valid_q;
   assign count          = count_q;
   assign overrun        = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_q, idle_d;
   logic          timeout_q, timeout_d;

   // Idle count saturates; timeout is set only on the cycle the limit is first reached.
   always_comb begin
      idle_d = idle_q;
      if (push || pop || empty) idle_d = '0;
      else if (idle_q != TW'(TIMEOUT_CYCLES)) idle_d = idle_q + TW'(1);

      timeout_d = timeout_q;
      if (status_clr || count_d == '0) timeout_d = 1'b0;
      if (idle_d == TW'(TIMEOUT_CYCLES) && idle_q != TW'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
   assign irq     = (count_q >= CW'(IRQ_THRESHOLD)) | overrun_q | timeout_q;
`else
   assign irq     = (count_q >= CW'(IRQ_THRESHOLD)) | overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: frame table, scoreboard of popped entries,
// and directed sequences for overrun, simultaneous push/pop, config flush and reset.

module tb_uart_rx_controller;
   import uart_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         rx_ready = 1'b0;
   logic [7:0]   rx_data = '0;
   logic         frame_error = 1'b0;
   logic         parity_error = 1'b0;
   logic         clear_rx_ready;
   uart_config_t uart_config;
   logic         cfg_wr_en = 1'b0;
   uart_config_t cfg_wr_data;
   logic         rd_en = 1'b0;
   logic [9:0]   rd_data;
   logic         rd_valid;
   logic [3:0]   count;
   logic         empty, full, overrun;
   logic         status_clr = 1'b0;
   logic         irq;
`ifdef UART_RX_TIMEOUT_EN
   logic         timeout;
`endif

   uart_rx_controller #(
      .DEPTH          (DEPTH),
      .IRQ_THRESHOLD  (1),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_ready       (rx_ready),
      .rx_data        (rx_data),
      .frame_error    (frame_error),
      .parity_error   (parity_error),
      .clear_rx_ready (clear_rx_ready),
      .uart_config    (uart_config),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_wr_data    (cfg_wr_data),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .count          (count),
      .empty          (empty),
      .full           (full),
      .overrun        (overrun),
      .status_clr     (status_clr),
`ifdef UART_RX_TIMEOUT_EN
      .timeout        (timeout),
`endif
      .irq            (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic [9:0] exp;
   } vec_t;

   vec_t       vecs [4];
   logic [9:0] sb [$];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clear(input logic v);
      for (int i = 0; i < 8 && clear_rx_ready !== v; i++) tick();
      check("clear_rx_ready", 32'(clear_rx_ready), 32'(v));
   endtask

   // Receiver model: drops rx_ready one cycle after it sees clear_rx_ready.
   task automatic send_frame(input logic [7:0] d, input logic fe, input logic pe,
                             input bit expect_push);
      rx_data = d; frame_error = fe; parity_error = pe; rx_ready = 1'b1;
      tick();
      if (expect_push) sb.push_back({pe, fe, d});
      wait_clear(1'b1);
      tick();
      rx_ready = 1'b0;
      wait_clear(1'b0);
   endtask

   task automatic sb_compare(input string name);
      logic [9:0] exp;
      check({name, "_valid"}, 32'(rd_valid), 32'd1);
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got 0x%0h with no entry expected", name, rd_data);
      end else begin
         exp = sb.pop_front();
         check({name, "_data"}, 32'(rd_data), 32'(exp));
      end
   endtask

   task automatic pop_check(input string name);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      sb_compare(name);
      tick();
      check({name, "_pulse"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      uart_config_t cfg_def, cfg_new;
      cfg_def = '{baud: BAUD_115200, data_bits: DATA_BITS_8, parity: PARITY_NONE,
                  stop_bits: STOP_BITS_1, lsb_first: 1'b1};
      cfg_new = '{baud: BAUD_9600, data_bits: DATA_BITS_7, parity: PARITY_ODD,
                  stop_bits: STOP_BITS_2, lsb_first: 1'b0};
      cfg_wr_data = cfg_def;

      vecs[0] = '{data: 8'hA5, fe: 1'b0, pe: 1'b0, exp: 10'h0A5};
      vecs[1] = '{data: 8'h3C, fe: 1'b1, pe: 1'b1, exp: 10'h33C};
      vecs[2] = '{data: 8'hFF, fe: 1'b0, pe: 1'b1, exp: 10'h2FF};
      vecs[3] = '{data: 8'h00, fe: 1'b1, pe: 1'b0, exp: 10'h100};

      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("rst_clear", 32'(clear_rx_ready), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_config", 32'(uart_config), 32'(cfg_def));

      // Single frames from the table, each read straight back.
      for (int i = 0; i < 4; i++) begin
         rx_data = vecs[i].data; frame_error = vecs[i].fe; parity_error = vecs[i].pe;
         rx_ready = 1'b1;
         tick();
         sb.push_back(vecs[i].exp);
         check("vec_count_after_push", 32'(count), 32'd1);
         check("vec_clear_high", 32'(clear_rx_ready), 32'd1);
         tick();
         rx_ready = 1'b0;
         wait_clear(1'b0);
         check("vec_count_one_push", 32'(count), 32'd1);
         check("vec_irq", 32'(irq), 32'd1);
         pop_check("vec_pop");
         check("vec_empty", 32'(empty), 32'd1);
         check("vec_irq_low", 32'(irq), 32'd0);
      end

      // Overflow: nine frames into eight slots, the last one lost.
      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0, i < 8);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      check("ovf_overrun", 32'(overrun), 32'd1);
      check("ovf_irq", 32'(irq), 32'd1);
      for (int i = 0; i < 8; i++) pop_check("ovf_pop");
      check("ovf_empty", 32'(empty), 32'd1);
      check("ovf_irq_sticky", 32'(irq), 32'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_pop_valid", 32'(rd_valid), 32'd0);
      check("empty_pop_hold", 32'(rd_data), 32'h007);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      check("clr_overrun", 32'(overrun), 32'd0);
      check("clr_irq", 32'(irq), 32'd0);

      // Push and pop on the same edge with count=4.
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
      rx_data = 8'h14; frame_error = 1'b0; parity_error = 1'b0;
      rx_ready = 1'b1; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      sb_compare("simul_pop");
      sb.push_back(10'h014);
      check("simul_count", 32'(count), 32'd4);
      wait_clear(1'b1);
      tick();
      rx_ready = 1'b0;
      wait_clear(1'b0);
      check("simul_count_after", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) pop_check("simul_order");

      // Pop while full does not make room for a push in the same cycle.
      for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b1);
      rx_data = 8'h28; frame_error = 1'b0; parity_error = 1'b0;
      rx_ready = 1'b1; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      sb_compare("fullpop");
      check("fullpop_count", 32'(count), 32'd7);
      check("fullpop_overrun", 32'(overrun), 32'd1);
      wait_clear(1'b1);
      tick();
      rx_ready = 1'b0;
      wait_clear(1'b0);
      for (int i = 0; i < 7; i++) pop_check("fullpop_order");

      // Config write flushes the FIFO and acknowledges a pending frame without pushing it.
      for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
      check("cfg_pre_count", 32'(count), 32'd3);
      cfg_wr_data = cfg_new; cfg_wr_en = 1'b1;
      rx_data = 8'h55; rx_ready = 1'b1;
      tick();
      cfg_wr_en = 1'b0;
      sb.delete();
      check("cfg_count", 32'(count), 32'd0);
      check("cfg_parity", 32'(uart_config.parity), 32'(PARITY_ODD));
      check("cfg_word", 32'(uart_config), 32'(cfg_new));
      check("cfg_ack", 32'(clear_rx_ready), 32'd1);
      tick();
      rx_ready = 1'b0;
      wait_clear(1'b0);
      check("cfg_no_push", 32'(count), 32'd0);
      check("cfg_overrun_kept", 32'(overrun), 32'd1);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      check("cfg_overrun_clr", 32'(overrun), 32'd0);

`ifdef UART_RX_TIMEOUT_EN
      begin
         int n;
         rx_data = 8'h77; rx_ready = 1'b1;
         tick();
         sb.push_back(10'h077);
         n = 0;
         while (n < 150 && timeout !== 1'b1) begin
            tick();
            n++;
            if (n == 1) rx_ready = 1'b0;
         end
         check("tmo_cycles", 32'(n), 32'd100);
         check("tmo_irq", 32'(irq), 32'd1);
         pop_check("tmo_pop");
         check("tmo_cleared", 32'(timeout), 32'd0);
      end
`endif

      // Reset in the middle of a handshake drops clear_rx_ready.
      rx_data = 8'h66; rx_ready = 1'b1;
      tick();
      check("midrst_clear_pre", 32'(clear_rx_ready), 32'd1);
      rst = 1'b0;
      tick();
      rx_ready = 1'b0;
      check("midrst_clear", 32'(clear_rx_ready), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      rst = 1'b1;
      tick();
      check("midrst_config", 32'(uart_config), 32'(cfg_def));
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side controller for the UART peripheral. Owns the `uart_config_t` register that drives `uart_receiver` and sequences that receiver's `rx_ready`/`clear_rx_ready` handshake. Drains each completed frame, with its error flags, into an internal FIFO. Exposes the FIFO, status and a level interrupt to the RV32E peripheral bus.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, 2..64
- `IRQ_THRESHOLD`, 1, FIFO count at or above which `irq` asserts; 1..DEPTH
- `TIMEOUT_CYCLES`, 40000, idle clocks before timeout interrupt; only used with `UART_RX_TIMEOUT_EN`
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low
- `rx_ready`  in  1  from receiver: frame complete
- `rx_data`  in  8  from receiver: received byte
- `frame_error`  in  1  from receiver
- `parity_error`  in  1  from receiver
- `clear_rx_ready`  out  1  to receiver: acknowledge frame
- `uart_config`  out  `uart_config_t`  configuration driven to receiver
- `cfg_wr_en`  in  1  load `cfg_wr_data` into config register
- `cfg_wr_data`  in  `uart_config_t`  new configuration
- `rd_en`  in  1  pop one FIFO entry
- `rd_data`  out  10  popped entry `{parity_error, frame_error, data[7:0]}`
- `rd_valid`  out  1  one-cycle pulse: `rd_data` updated
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `empty`, `full`  out  1  FIFO flags
- `overrun`  out  1  sticky: frame dropped because FIFO was full
- `status_clr`  in  1  clear `overrun` (and `timeout` when enabled)
- `irq`  out  1  level interrupt

## Operation
- Handshake FSM with states WAIT, ACK:
  - **WAIT:** when `rx_ready`=1, capture `{parity_error, frame_error, rx_data}`.
    - If the FIFO is not full, push the entry.
    - If the FIFO is full, drop the entry and set `overrun`.
    - In either case, register `clear_rx_ready`=1 and go to ACK.
  - **ACK:** hold `clear_rx_ready`=1 until `rx_ready` is sampled 0, then deassert `clear_rx_ready` and return to WAIT.
  - Exactly one push or drop occurs per frame.
- FIFO:
  - Circular buffer with head/tail pointers modulo DEPTH.
  - `count` ranges 0..DEPTH.
  - `empty` = (`count`==0); `full` = (`count`==DEPTH).
- Pop:
  - `rd_en` with `!empty` registers the head entry into `rd_data`, pulses `rd_valid`, and advances the head.
  - `rd_en` while empty is ignored: `rd_data` is held and there is no `rd_valid` pulse.
- Simultaneous push and pop: both occur and `count` is unchanged. A pop with `count`=DEPTH frees space in that same cycle, but a push in that cycle still sees full and is dropped. The full decision uses the pre-cycle `count`.
- `cfg_wr_en`:
  - Loads `uart_config` on the next edge.
  - Flushes the FIFO (`count`←0, pointers←0).
  - Forces the FSM to ACK when `rx_ready`=1, so the stale frame is acknowledged without being pushed.
  - `overrun` is preserved.
- `status_clr` and an overrun event in the same cycle: the set wins.
- `irq` = (`count` >= IRQ_THRESHOLD) | `overrun` (| `timeout` when enabled); combinational from registers.

## Timing
- Reset values:
  - `clear_rx_ready`=0, `rd_data`=0, `rd_valid`=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `irq`=0, FSM=WAIT.
  - `uart_config` = {BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, `lsb_first`=1}.
- Reset mid-handshake: `clear_rx_ready` drops at the reset edge. The receiver's own reset clears `rx_ready`.
- `rx_ready` sampled high at edge N: the entry is in the FIFO and `clear_rx_ready`=1 after edge N. `count` increments after edge N.
- Receiver drops `rx_ready` one cycle after seeing `clear_rx_ready`; `clear_rx_ready` deasserts one edge after that. The minimum handshake is 3 cycles, far shorter than one frame.
- `rd_en` at edge N: `rd_data` is valid and `rd_valid`=1 during cycle N+1.
- `uart_config` changes one cycle after `cfg_wr_en`.

## Configuration
- Macro `UART_RX_TIMEOUT_EN`.
- **Defined:**
  - An idle counter resets to 0 on every push, every pop, and whenever the FIFO is empty; otherwise it increments.
  - On reaching TIMEOUT_CYCLES it sets a sticky `timeout` bit, which is ORed into `irq`.
  - `timeout` is cleared by `status_clr` or by the FIFO becoming empty.
  - A `timeout` output port (1 bit) is added.
- **Undefined:** no counter, no `timeout` port, and `irq` excludes timeout.

## Test plan
- One frame, data 0xA5 with no errors: `rx_ready` pulse → `count`=1 and `clear_rx_ready` high until `rx_ready` falls. Then `rd_en` → `rd_data`=0x0A5 with `rd_valid` for 1 cycle, and `empty`=1.
- Frame 0x3C with `frame_error`=1 and `parity_error`=1 → `rd_data`=0x33C.
- DEPTH=8: push 9 frames (0x00..0x08) with no reads → `full`=1, `overrun`=1, `irq`=1. Pops return 0x00..0x07, and 0x08 is lost. `status_clr` → `overrun`=0.
- With `count`=4, pop on the same edge `rx_ready` is captured → `count` stays 4, and FIFO order is preserved.
- `cfg_wr_en` with PARITY_ODD while `count`=3 → `count`=0 and `uart_config.parity`=PARITY_ODD next cycle. A pending `rx_ready` is acknowledged without a push.
- `UART_RX_TIMEOUT_EN`, TIMEOUT_CYCLES=100, IRQ_THRESHOLD=4: one frame, no reads → `timeout`=1 and `irq`=1 exactly 100 cycles after the push. A pop clears `timeout`.
